// File: rtl/lifo_fifo_pkg.sv
// Shared types and helpers for the selectable LIFO/FIFO buffer.
package lifo_fifo_pkg;

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } buf_mode_t;

    // Occupancy after one cycle, given which of push/pop were accepted.
    function automatic int unsigned next_count(
        input int unsigned cnt,
        input logic        push_acc,
        input logic        pop_acc
    );
        case ({push_acc, pop_acc})
            2'b10:   return cnt + 32'd1;
            2'b01:   return cnt - 32'd1;
            default: return cnt;
        endcase
    endfunction

endpackage

// File: rtl/lifo_fifo_ram.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module lifo_fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read sees the pre-edge contents, so same-address write+read returns old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_fifo_buffer.sv
// Single-cycle buffer operating as a stack (LIFO) or queue (FIFO), mode latched while empty.
module lifo_fifo_buffer
    import lifo_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              mode_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned   CW       = ADDR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    buf_mode_t         mode_q, mode_d;

    logic              full, empty;
    logic              push_acc, pop_acc;
    logic              we;
    logic [ADDR_W-1:0] waddr, raddr, top_idx;
    logic [DATA_W-1:0] rdata;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop_acc  = pop_i && !empty && !clear_i;
    assign push_acc = push_i && (!full || pop_acc) && !clear_i;
    assign top_idx  = count_q[ADDR_W-1:0] - ADDR_W'(1);
    assign we       = push_acc;

    // LIFO push+pop overwrites the current top instead of growing the stack.
    always_comb begin
        if (mode_q == MODE_LIFO) begin
            raddr = top_idx;
            waddr = pop_acc ? top_idx : count_q[ADDR_W-1:0];
        end else begin
            raddr = rd_ptr_q;
            waddr = wr_ptr_q;
        end
    end

    lifo_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (din_i),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        mode_d   = mode_q;

        if (clear_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_i && !push_acc) ovf_d = 1'b1;
            if (pop_i && !pop_acc)   udf_d = 1'b1;
            count_d = CW'(next_count(32'(count_q), push_acc, pop_acc));
            if (mode_q == MODE_FIFO) begin
                if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (pop_acc) begin
                dout_d  = rdata;
                valid_d = 1'b1;
            end
        end

        if (count_d == '0) begin
            mode_d = buf_mode_t'(mode_i);
        end
        // Pointers idle at zero in LIFO so a later switch to FIFO starts clean.
        if (mode_d == MODE_LIFO) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            mode_q   <= MODE_LIFO;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            mode_q   <= mode_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign full_o       = full;
    assign empty_o      = empty;
    assign count_o      = count_q;
    assign mode_o       = mode_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = udf_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Scoreboard bench for lifo_fifo_buffer: behavioural queue model plus expected-read queue.
module tb_lifo_fifo_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              mode_i  = 1'b0;
    logic              clear_i = 1'b0;
    logic              push_i  = 1'b0;
    logic              pop_i   = 1'b0;
    logic [DATA_W-1:0] din_i   = '0;
    logic [DATA_W-1:0] dout_o;
    logic              dout_valid_o;
    logic              full_o;
    logic              empty_o;
    logic [ADDR_W:0]   count_o;
    logic              mode_o;
    logic              overflow_o;
    logic              underflow_o;

    lifo_fifo_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .clear_i      (clear_i),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .din_i        (din_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .mode_o       (mode_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mdl[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              m_mode  = 1'b0;
    logic              m_ovf   = 1'b0;
    logic              m_udf   = 1'b0;
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_dout  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        mdl.delete();
        exp_q.delete();
        m_mode  = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = '0;
    endtask

    task automatic check_state(input string ph);
        logic [DATA_W-1:0] e;
        check_eq({ph, ":valid"}, 32'(dout_valid_o), 32'(m_valid));
        if (dout_valid_o) begin
            check_eq({ph, ":sb_pending"}, 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq({ph, ":dout"}, 32'(dout_o), 32'(e));
            end
        end
        check_eq({ph, ":dout_hold"}, 32'(dout_o), 32'(m_dout));
        check_eq({ph, ":count"}, 32'(count_o), 32'(mdl.size()));
        check_eq({ph, ":full"}, 32'(full_o), 32'(mdl.size() == DEPTH));
        check_eq({ph, ":empty"}, 32'(empty_o), 32'(mdl.size() == 0));
        check_eq({ph, ":overflow"}, 32'(overflow_o), 32'(m_ovf));
        check_eq({ph, ":underflow"}, 32'(underflow_o), 32'(m_udf));
        check_eq({ph, ":mode"}, 32'(mode_o), 32'(m_mode));
    endtask

    task automatic cycle(input string ph, input logic p, input logic q,
                         input logic [DATA_W-1:0] d, input logic m, input logic c);
        logic pop_ok, push_ok;
        logic [DATA_W-1:0] v;
        push_i  = p;
        pop_i   = q;
        din_i   = d;
        mode_i  = m;
        clear_i = c;
        m_valid = 1'b0;
        if (c) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop_ok  = q && (mdl.size() > 0);
            push_ok = p && ((mdl.size() < DEPTH) || pop_ok);
            if (p && !push_ok) m_ovf = 1'b1;
            if (q && !pop_ok)  m_udf = 1'b1;
            if (pop_ok) begin
                v = m_mode ? mdl.pop_front() : mdl.pop_back();
                exp_q.push_back(v);
                m_dout  = v;
                m_valid = 1'b1;
            end
            if (push_ok) mdl.push_back(d);
        end
        if (mdl.size() == 0) m_mode = m;
        @(posedge clk);
        #1;
        check_state(ph);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LIFO ordering
        cycle("lifo_push", 1, 0, 8'h11, 0, 0);
        cycle("lifo_push", 1, 0, 8'h22, 0, 0);
        cycle("lifo_push", 1, 0, 8'h33, 0, 0);
        repeat (3) cycle("lifo_pop", 0, 1, 8'h00, 0, 0);

        // FIFO ordering and pointer wrap
        cycle("to_fifo", 0, 0, 8'h00, 1, 0);
        cycle("fifo_push", 1, 0, 8'h11, 1, 0);
        cycle("fifo_push", 1, 0, 8'h22, 1, 0);
        cycle("fifo_push", 1, 0, 8'h33, 1, 0);
        repeat (3) cycle("fifo_pop", 0, 1, 8'h00, 1, 0);
        for (int i = 0; i < 40; i++) begin
            cycle("wrap_push", 1, 0, 8'(8'h80 + i), 1, 0);
            cycle("wrap_pop", 0, 1, 8'h00, 1, 0);
        end

        // Full, overflow, push+pop while full
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, 8'(8'h40 + i), 1, 0);
        cycle("overflow", 1, 0, 8'hAA, 1, 0);
        cycle("full_pushpop", 1, 1, 8'hBB, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 1, 8'h00, 1, 0);

        // Underflow and LIFO replace-top
        cycle("underflow", 0, 1, 8'h00, 1, 0);
        cycle("to_lifo", 0, 0, 8'h00, 0, 0);
        cycle("lifo_fill", 1, 0, 8'h01, 0, 0);
        cycle("lifo_fill", 1, 0, 8'h02, 0, 0);
        cycle("lifo_fill", 1, 0, 8'h03, 0, 0);
        cycle("lifo_replace", 1, 1, 8'h5A, 0, 0);
        repeat (3) cycle("lifo_drain", 0, 1, 8'h00, 0, 0);
        cycle("empty_pushpop", 1, 1, 8'h66, 0, 0);
        cycle("lifo_drain1", 0, 1, 8'h00, 0, 0);

        // Mode change only at empty
        cycle("mode_push", 1, 0, 8'hA1, 0, 0);
        cycle("mode_push", 1, 0, 8'hA2, 0, 0);
        cycle("mode_ignored", 0, 0, 8'h00, 1, 0);
        cycle("mode_pop", 0, 1, 8'h00, 1, 0);
        cycle("mode_pop_last", 0, 1, 8'h00, 1, 0);

        // Clear with flags set
        cycle("pre_ovf", 0, 1, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) cycle("pre_clear", 1, 0, 8'(8'hC0 + i), 1, 0);
        for (int i = 0; i < DEPTH - 5; i++) cycle("pre_fill", 1, 0, 8'(8'hD0 + i), 1, 0);
        cycle("set_ovf", 1, 0, 8'hEE, 1, 0);
        for (int i = 0; i < DEPTH - 5; i++) cycle("trim", 0, 1, 8'h00, 1, 0);
        cycle("clear", 1, 1, 8'hFF, 1, 1);
        cycle("post_clear", 1, 0, 8'h12, 1, 0);
        cycle("post_clear_pop", 0, 1, 8'h00, 1, 0);

        // Asynchronous reset mid-burst
        cycle("burst", 1, 0, 8'h10, 1, 0);
        cycle("burst", 1, 0, 8'h20, 1, 0);
        cycle("burst_pop", 1, 1, 8'h30, 1, 0);
        push_i = 1'b1;
        din_i  = 8'h40;
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_state("rst_async");
        @(negedge clk);
        rst_n  = 1'b1;
        push_i = 1'b0;
        cycle("after_rst", 1, 1, 8'h77, 0, 0);
        cycle("after_rst_pop", 0, 1, 8'h00, 0, 0);

        check_eq("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_fifo_buffer.md
Name: lifo_fifo_buffer

Overview:
Parametrised single-clock buffer with a selectable mode: LIFO (stack) or FIFO (queue).
- Next generation of the team's 8-bit stack block.
- Adds configurable width and depth, full/empty flags, an occupancy count, sticky error flags and a synchronous flush.
- Completes every operation in one cycle; the old block needed two.
- Sits behind the tt_um top level. ui_in/uio_in drive control and data; uo_out shows dout.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of entries; power of two, minimum 2
ADDR_W, $clog2(DEPTH), derived pointer width; not to be overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
mode_i  in  1  0 = LIFO, 1 = FIFO; takes effect only while empty
clear_i  in  1  synchronous flush; highest priority
push_i  in  1  write din_i this cycle
pop_i  in  1  read one entry this cycle
din_i  in  DATA_W  write data
dout_o  out  DATA_W  registered read data
dout_valid_o  out  1  one-cycle pulse, cycle after an accepted pop
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
count_o  out  ADDR_W+1  current occupancy, 0..DEPTH
mode_o  out  1  mode currently in force
overflow_o  out  1  sticky; set when a push is rejected
underflow_o  out  1  sticky; set when a pop is rejected

Behaviour:
Reset values:
- All pointers and count are 0; dout_o = 0; dout_valid_o = 0.
- empty_o = 1; full_o = 0; overflow_o = 0; underflow_o = 0; mode_o = 0 (LIFO).
- Storage array is not reset; its contents are don't-care.
- Reset asserted mid-operation aborts everything immediately; the first cycle after release behaves as empty.

Mode:
- mode_o loads from mode_i on any clock edge where the post-update count is 0.
- While non-empty, changes on mode_i are ignored.

clear_i:
- Pointers and count go to 0, and overflow/underflow are cleared.
- push/pop in the same cycle are ignored, dout_valid_o = 0, and dout_o holds its value.

Accept rules:
- A push is accepted if not full, or if a pop is accepted in the same cycle.
- A pop is accepted if not empty.
- Rejected push sets overflow_o; rejected pop sets underflow_o. Neither changes storage or pointers.

LIFO mode (top entry at index count-1):
- push only: mem[count] <= din; count+1.
- pop only: dout_o <= mem[count-1]; count-1.
- push+pop, non-empty: dout_o <= old mem[count-1]; mem[count-1] <= din; count unchanged. Allowed when full.
- push+pop, empty: push accepted, pop rejected, underflow set.

FIFO mode:
- push: mem[wr_ptr] <= din; wr_ptr+1, wrapping modulo DEPTH.
- pop: dout_o <= mem[rd_ptr]; rd_ptr+1, wrapping.
- push+pop, non-empty: both proceed and count is unchanged. Allowed when full.
- push+pop, empty: push only, underflow set. No fall-through.

Timing and flags:
- Read latency is 1 cycle. dout_o and dout_valid_o update on the edge that accepts the pop.
- dout_o holds its last value until the next accepted pop.
- full_o, empty_o and count_o are registered and reflect state after the edge.
- In LIFO mode wr_ptr and rd_ptr are unused and held at 0. Switching mode at empty therefore starts from a clean state.

Decomposition:
- Package lifo_fifo_pkg holds:
  - typedef enum logic {MODE_LIFO = 0, MODE_FIFO = 1} buf_mode_t;
  - a function computing the next count for a push/pop/accept combination.
- Sub-module lifo_fifo_ram: DEPTH x DATA_W register file, one write port and one asynchronous-read port, no reset.
  - The parent registers dout.
  - Write and read at the same address in the same cycle return the old data; this is what LIFO replace-top relies on.

Test Plan:
1. LIFO, DEPTH=16: push 0x11, 0x22, 0x33, then 3 pops -> dout 0x33, 0x22, 0x11, each with a dout_valid pulse; empty_o=1 after the last pop.
2. FIFO: push 0x11, 0x22, 0x33, then 3 pops -> dout 0x11, 0x22, 0x33. Then 40 alternating push/pop pairs -> pointers wrap, data order preserved, count_o ends at 0.
3. Fill 16 entries, then push 0xAA -> full_o=1, overflow_o=1, count_o stays 16. Simultaneous push 0xBB + pop while full (FIFO) -> pops the oldest entry, count_o stays 16, no new overflow.
4. pop on empty -> underflow_o=1 sticky, dout_valid_o=0. LIFO push 0x5A + pop with count=3 -> dout = old top, new top = 0x5A, count_o=3.
5. Mode change: push 2 entries in LIFO, set mode_i=1 -> mode_o stays 0. Pop both -> mode_o=1 on the edge where count reaches 0.
6. clear_i with count=5 and both error flags set -> count_o=0, flags cleared. Assert rst_n low mid-burst -> all outputs at reset values asynchronously.
